// File: rtl/fft_stage_sequencer_if.sv
// Signal bundle between the FFT top control, the stage sequencer and the butterfly unit.
// FFT_SEQ_ABORT_EN adds the abort request and aborted status pair.
interface fft_stage_sequencer_if #(
    parameter int FFT_N     = 10,
    parameter int FFT_BFPDW = 5,
    parameter int EXPW      = 9
);
    logic                 start;
    logic                 ifft_in;
    logic                 busy;
    logic                 done;
    logic [EXPW-1:0]      bfp_exp;
    logic                 bf_iact;
    logic [1:0]           bf_ictrl;
    logic [FFT_N-2:0]     bf_MemAddr;
    logic [FFT_N-2:0]     bf_twaddr;
    logic                 bf_evenOdd;
    logic                 bf_ifft;
    logic                 bf_clr_bfp;
    logic [FFT_BFPDW-1:0] bf_ibfp;
    logic                 bf_oact;
    logic [FFT_BFPDW-1:0] bf_obfp;
`ifdef FFT_SEQ_ABORT_EN
    logic                 abort;
    logic                 aborted;

    modport slave (
        input  start, ifft_in, bf_oact, bf_obfp, abort,
        output busy, done, bfp_exp, bf_iact, bf_ictrl, bf_MemAddr, bf_twaddr,
               bf_evenOdd, bf_ifft, bf_clr_bfp, bf_ibfp, aborted
    );
    modport master (
        output start, ifft_in, bf_oact, bf_obfp, abort,
        input  busy, done, bfp_exp, bf_iact, bf_ictrl, bf_MemAddr, bf_twaddr,
               bf_evenOdd, bf_ifft, bf_clr_bfp, bf_ibfp, aborted
    );
`else
    modport slave (
        input  start, ifft_in, bf_oact, bf_obfp,
        output busy, done, bfp_exp, bf_iact, bf_ictrl, bf_MemAddr, bf_twaddr,
               bf_evenOdd, bf_ifft, bf_clr_bfp, bf_ibfp
    );
    modport master (
        output start, ifft_in, bf_oact, bf_obfp,
        input  busy, done, bfp_exp, bf_iact, bf_ictrl, bf_MemAddr, bf_twaddr,
               bf_evenOdd, bf_ifft, bf_clr_bfp, bf_ibfp
    );
`endif
endinterface

// File: rtl/fft_stage_sequencer.sv
// Radix-2 FFT stage sequencer: issues butterflies per stage, tracks write-backs, chains BFP exponent.
// Optional abort path enabled by defining FFT_SEQ_ABORT_EN.
//
// state   | meaning
// IDLE    | waiting for start
// CLR     | one-cycle clear of the butterfly bfp tracker
// ISSUE   | one butterfly issued per cycle
// DRAIN   | waiting for outstanding write-backs
// LATCH   | capture stage exponent, advance stage
// FIN     | done pulse
module fft_stage_sequencer #(
    parameter int FFT_N     = 10,
    parameter int FFT_BFPDW = 5,
    parameter int EXPW      = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    fft_stage_sequencer_if.slave  sif
);
    localparam int AW   = FFT_N - 1;
    localparam int CW   = FFT_N;
    localparam int SW   = (FFT_N > 2) ? $clog2(FFT_N) : 1;
    localparam int SUMW = EXPW + 1;
    localparam logic [CW-1:0] HALF = CW'(1) << AW;

    typedef enum logic [2:0] {S_IDLE, S_CLR, S_ISSUE, S_DRAIN, S_LATCH, S_FIN} state_t;

    state_t               state_q, state_d;
    logic [SW-1:0]        s_q, s_d;
    logic [CW-1:0]        j_q, j_d, c_q, c_d, c_nx;
    logic                 busy_q, busy_d, done_q, done_d;
    logic [EXPW-1:0]      bfp_exp_q, bfp_exp_d;
    logic                 iact_q, iact_d, eo_q, eo_d, ifft_q, ifft_d, clr_q, clr_d;
    logic [1:0]           ictrl_q, ictrl_d;
    logic [AW-1:0]        addr_q, addr_d, tw_q, tw_d, issue_idx;
    logic [FFT_BFPDW-1:0] ibfp_q, ibfp_d;
    logic [SUMW-1:0]      exp_sum;
    logic                 issue, oact_cnt;
`ifdef FFT_SEQ_ABORT_EN
    logic                 abort_q, abort_d, aborted_q, aborted_d;
`endif

    // Write-backs are only counted while a stage is open; the count saturates at one stage's worth.
    assign oact_cnt = sif.bf_oact && (state_q == S_CLR || state_q == S_ISSUE || state_q == S_DRAIN);
    assign c_nx     = (oact_cnt && c_q != HALF) ? c_q + CW'(1) : c_q;
    assign exp_sum  = SUMW'(bfp_exp_q) + SUMW'(sif.bf_obfp);

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        j_d       = j_q;
        c_d       = c_nx;
        bfp_exp_d = bfp_exp_q;
        ibfp_d    = ibfp_q;
        ifft_d    = ifft_q;
        clr_d     = 1'b0;
        done_d    = 1'b0;
        issue     = 1'b0;
        issue_idx = '0;
`ifdef FFT_SEQ_ABORT_EN
        abort_d   = abort_q;
        aborted_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: if (sif.start) begin
                state_d   = S_CLR;
                ifft_d    = sif.ifft_in;
                s_d       = '0;
                bfp_exp_d = '0;
                ibfp_d    = '0;
                j_d       = '0;
                c_d       = '0;
                clr_d     = 1'b1;
`ifdef FFT_SEQ_ABORT_EN
                abort_d   = 1'b0;
`endif
            end
            S_CLR: begin
`ifdef FFT_SEQ_ABORT_EN
                if (sif.abort) begin
                    state_d = S_DRAIN;
                    abort_d = 1'b1;
                end else
`endif
                begin
                    state_d   = S_ISSUE;
                    issue     = 1'b1;
                    issue_idx = '0;
                    j_d       = CW'(1);
                end
            end
            S_ISSUE: begin
`ifdef FFT_SEQ_ABORT_EN
                if (sif.abort) begin
                    state_d = S_DRAIN;
                    abort_d = 1'b1;
                end else
`endif
                if (j_q == HALF) begin
                    state_d = S_DRAIN;
                end else begin
                    issue     = 1'b1;
                    issue_idx = j_q[AW-1:0];
                    j_d       = j_q + CW'(1);
                end
            end
            S_DRAIN: begin
`ifdef FFT_SEQ_ABORT_EN
                // After an abort, j holds the number of butterflies actually issued.
                if (abort_q) begin
                    if (c_nx >= j_q) begin
                        state_d   = S_IDLE;
                        aborted_d = 1'b1;
                    end
                end else
`endif
                if (c_nx == HALF) state_d = S_LATCH;
            end
            S_LATCH: begin
                ibfp_d    = sif.bf_obfp;
                bfp_exp_d = exp_sum[EXPW] ? '1 : exp_sum[EXPW-1:0];
                if (s_q == SW'(FFT_N - 1)) begin
                    state_d = S_FIN;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_CLR;
                    s_d     = s_q + SW'(1);
                    j_d     = '0;
                    c_d     = '0;
                    clr_d   = 1'b1;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d  = (state_d != S_IDLE);
        eo_d    = busy_d & s_d[0];
        iact_d  = issue;
        addr_d  = issue ? issue_idx : '0;
        tw_d    = issue ? AW'((issue_idx >> s_q) << s_q) : '0;
        ictrl_d = issue ? {s_q == '0, s_q == SW'(FFT_N - 1)} : 2'b00;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            s_q       <= '0;
            j_q       <= '0;
            c_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bfp_exp_q <= '0;
            iact_q    <= 1'b0;
            ictrl_q   <= 2'b00;
            addr_q    <= '0;
            tw_q      <= '0;
            eo_q      <= 1'b0;
            ifft_q    <= 1'b0;
            clr_q     <= 1'b0;
            ibfp_q    <= '0;
`ifdef FFT_SEQ_ABORT_EN
            abort_q   <= 1'b0;
            aborted_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            j_q       <= j_d;
            c_q       <= c_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bfp_exp_q <= bfp_exp_d;
            iact_q    <= iact_d;
            ictrl_q   <= ictrl_d;
            addr_q    <= addr_d;
            tw_q      <= tw_d;
            eo_q      <= eo_d;
            ifft_q    <= ifft_d;
            clr_q     <= clr_d;
            ibfp_q    <= ibfp_d;
`ifdef FFT_SEQ_ABORT_EN
            abort_q   <= abort_d;
            aborted_q <= aborted_d;
`endif
        end
    end

    assign sif.busy       = busy_q;
    assign sif.done       = done_q;
    assign sif.bfp_exp    = bfp_exp_q;
    assign sif.bf_iact    = iact_q;
    assign sif.bf_ictrl   = ictrl_q;
    assign sif.bf_MemAddr = addr_q;
    assign sif.bf_twaddr  = tw_q;
    assign sif.bf_evenOdd = eo_q;
    assign sif.bf_ifft    = ifft_q;
    assign sif.bf_clr_bfp = clr_q;
    assign sif.bf_ibfp    = ibfp_q;
`ifdef FFT_SEQ_ABORT_EN
    assign sif.aborted    = aborted_q;
`endif
endmodule
